// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl_pkg.sv
// Shared TPL DAC definitions: start-sequencer state encoding.
package ad_ip_jesd204_tpl_dac_start_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } dac_start_state_e;

endpackage

// File: rtl/sync_bits.sv
// Multi-flop CDC synchroniser for quasi-static or slow single-bit signals.
module sync_bits #(
  parameter int NUM_OF_BITS = 1,
  parameter int ASYNC_CLK   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic [NUM_OF_BITS-1:0] in_bits,
  input  logic                   out_resetn,
  input  logic                   out_clk,
  output logic [NUM_OF_BITS-1:0] out_bits
);

  if (ASYNC_CLK != 0) begin : g_sync
    logic [NUM_OF_BITS-1:0] stage_q [SYNC_STAGES];

    // NOTE: every flop here is plain state, not a memory, so each one is reset.
    always_ff @(posedge out_clk or negedge out_resetn) begin
      if (!out_resetn) begin
        for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= in_bits;
        for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign out_bits = stage_q[SYNC_STAGES-1];
  end else begin : g_bypass
    assign out_bits = in_bits;
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Start/stop sequencer for the TPL DAC: gates DMA requests and data,
// supports immediate or externally triggered start, counts underflows.
module ad_ip_jesd204_tpl_dac_start_ctrl
  import ad_ip_jesd204_tpl_dac_start_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int DATA_LATENCY  = 1,
  parameter int UNF_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     ext_sync_mode,
  input  logic                     ext_sync_in,
  input  logic [NUM_CHANNELS-1:0]  enable,
  input  logic                     link_ready,
  input  logic                     dac_dunf,
  output logic [NUM_CHANNELS-1:0]  dac_valid,
  output logic                     data_gate,
  output logic                     armed,
  output logic                     running,
  output logic [UNF_CNT_WIDTH-1:0] unf_count
);

  dac_start_state_e         state_q, state_d;
  logic                     ext_sync_s;
  logic                     sync_prev_q;
  logic                     trig_s;
  logic                     run_s;
  logic                     gate_in_s;
  logic                     arm_accept_s;
  logic [DATA_LATENCY-1:0]  gate_q;
  logic [UNF_CNT_WIDTH-1:0] unf_q, unf_d;
  logic                     armed_q, running_q;

  sync_bits #(
    .NUM_OF_BITS (1),
    .ASYNC_CLK   (1),
    .SYNC_STAGES (SYNC_STAGES)
  ) i_ext_sync (
    .in_bits    (ext_sync_in),
    .out_resetn (resetn),
    .out_clk    (clk),
    .out_bits   (ext_sync_s)
  );

  // Only a fresh rising edge counts; a level held across arm never starts.
  assign trig_s = ext_sync_s & ~sync_prev_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arm && !stop) state_d = ext_sync_mode ? ST_ARMED : ST_RUN;
      ST_ARMED: if (stop) state_d = ST_IDLE;
                else if (trig_s) state_d = ST_RUN;
      ST_RUN:   if (stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_s        = (state_q == ST_RUN);
    gate_in_s    = run_s & link_ready;
    dac_valid    = gate_in_s ? enable : '0;
    arm_accept_s = (state_q == ST_IDLE) & arm & ~stop;
  end

  // Clear on accepted arm has priority over counting; count sticks at all-ones.
  always_comb begin
    unf_d = unf_q;
    if (arm_accept_s)                       unf_d = '0;
    else if (run_s && dac_dunf && ~&unf_q)  unf_d = unf_q + UNF_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_prev_q <= 1'b0;
      gate_q      <= '0;
      unf_q       <= '0;
      armed_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      sync_prev_q <= ext_sync_s;
      gate_q[0]   <= gate_in_s;
      for (int i = 1; i < DATA_LATENCY; i++) gate_q[i] <= gate_q[i-1];
      unf_q       <= unf_d;
      armed_q     <= (state_d == ST_ARMED);
      running_q   <= (state_d == ST_RUN);
    end
  end

  assign data_gate = gate_q[DATA_LATENCY-1];
  assign armed     = armed_q;
  assign running   = running_q;
  assign unf_count = unf_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Self-checking bench: directed table, corner sequences, random run vs model.
module tb_ad_ip_jesd204_tpl_dac_start_ctrl;

  localparam int NC = 2;
  localparam int SS = 2;
  localparam int DL = 3;
  localparam int UW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          arm = 1'b0, stop = 1'b0, ext_sync_mode = 1'b0, ext_sync_in = 1'b0;
  logic [NC-1:0] enable = '0;
  logic          link_ready = 1'b0, dac_dunf = 1'b0;
  logic [NC-1:0] dac_valid;
  logic          data_gate, armed, running;
  logic [UW-1:0] unf_count;

  int total = 0;
  int bad = 0;

  ad_ip_jesd204_tpl_dac_start_ctrl #(
    .NUM_CHANNELS(NC), .SYNC_STAGES(SS), .DATA_LATENCY(DL), .UNF_CNT_WIDTH(UW)
  ) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .stop(stop),
    .ext_sync_mode(ext_sync_mode), .ext_sync_in(ext_sync_in),
    .enable(enable), .link_ready(link_ready), .dac_dunf(dac_dunf),
    .dac_valid(dac_valid), .data_gate(data_gate), .armed(armed),
    .running(running), .unf_count(unf_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = waiting for trigger, 2 = transmitting.
  int            m_mode;
  logic [UW-1:0] m_cnt;
  logic          m_gate_hist[$];
  logic          m_ext_hist[$];

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = '0;
    m_gate_hist.delete();
    repeat (DL) m_gate_hist.push_back(1'b0);
    m_ext_hist.delete();
    repeat (SS + 1) m_ext_hist.push_back(1'b0);
  endtask

  task automatic model_update();
    logic rise;
    logic xmit;
    // The trigger input seen SS-1 samples ago must be high and the one before low.
    rise = m_ext_hist[SS-1] && !m_ext_hist[SS];
    xmit = (m_mode == 2);
    m_gate_hist.push_back(xmit && link_ready);
    void'(m_gate_hist.pop_front());
    if (arm && !stop && m_mode == 0) m_cnt = '0;
    else if (xmit && dac_dunf && m_cnt != {UW{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (stop) m_mode = 0;
    else if (m_mode == 0 && arm) m_mode = ext_sync_mode ? 1 : 2;
    else if (m_mode == 1 && rise) m_mode = 2;
    m_ext_hist.push_front(ext_sync_in);
    void'(m_ext_hist.pop_back());
  endtask

  function automatic logic [8:0] dut_vec();
    return {dac_valid, data_gate, armed, running, unf_count};
  endfunction

  function automatic logic [8:0] model_vec();
    logic [NC-1:0] dv;
    dv = (m_mode == 2 && link_ready) ? enable : '0;
    return {dv, m_gate_hist[0], m_mode == 1, m_mode == 2, m_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_update();
    #1;
    check(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic pulse_clear();
    arm = 1'b0; stop = 1'b0; dac_dunf = 1'b0;
  endtask

  typedef struct {
    logic          arm, stop, mode, dunf;
    logic [NC-1:0] en;
    logic [8:0]    exp;  // {dac_valid, data_gate, armed, running, unf_count}
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'b00_0_0_0_0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 9'b00_0_0_0_0000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 9'b11_0_0_1_0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'b11_0_0_1_0000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 9'b11_0_0_1_0001};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 9'b01_1_0_1_0010};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 9'b00_1_0_0_0010};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 9'b00_1_0_0_0010};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'b00_1_0_0_0010};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'b00_0_0_0_0010};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 9'b00_0_1_0_0000};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 9'b00_0_0_0_0000};

    model_reset();
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    link_ready = 1'b1;

    // Directed table: arbitration, counting, stop latency, arm-then-stop.
    for (int i = 0; i < 12; i++) begin
      arm = tbl[i].arm; stop = tbl[i].stop; ext_sync_mode = tbl[i].mode;
      dac_dunf = tbl[i].dunf; enable = tbl[i].en;
      step("tbl_model");
      check($sformatf("tbl_row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end
    pulse_clear();

    // Triggered start: RUN exactly SS edges after first high sample.
    ext_sync_mode = 1'b1; arm = 1'b1;
    step("trig_arm");
    arm = 1'b0;
    check("trig_armed", 32'(armed), 32'd1);
    repeat (20) begin
      step("trig_wait");
      check("trig_still_armed", 32'(armed), 32'd1);
    end
    ext_sync_in = 1'b1;
    for (int i = 0; i < SS; i++) begin
      step("trig_sync");
      check("trig_not_yet", 32'(running), 32'd0);
    end
    step("trig_go");
    check("trig_running", 32'(running), 32'd1);
    check("trig_armed_low", 32'(armed), 32'd0);
    ext_sync_in = 1'b0; stop = 1'b1;
    step("trig_stop");
    stop = 1'b0;

    // Trigger edge while idle is not remembered.
    repeat (3) step("pre_idle");
    ext_sync_in = 1'b1;
    repeat (4) begin
      step("pre_edge_idle");
      check("pre_edge_no_start", 32'(running), 32'd0);
    end
    arm = 1'b1;
    step("pre_arm");
    arm = 1'b0;
    repeat (6) begin
      step("pre_hold");
      check("pre_no_stored_edge", 32'({armed, running}), 32'b10);
    end
    stop = 1'b1;
    step("pre_stop");
    stop = 1'b0; ext_sync_in = 1'b0; ext_sync_mode = 1'b0;

    // link_ready drop in RUN.
    enable = 2'b11; arm = 1'b1;
    step("lr_arm");
    arm = 1'b0;
    repeat (3) step("lr_run");
    link_ready = 1'b0;
    repeat (5) begin
      step("lr_low");
      check("lr_keep_running", 32'({running, dac_valid}), 32'b100);
    end
    link_ready = 1'b1;
    repeat (5) step("lr_high");

    // Underflow saturation, hold in idle, clear on arm.
    dac_dunf = 1'b1;
    repeat (20) step("unf_run");
    check("unf_saturated", 32'(unf_count), 32'd15);
    stop = 1'b1;
    step("unf_stop");
    stop = 1'b0;
    repeat (5) step("unf_idle");
    check("unf_hold_idle", 32'(unf_count), 32'd15);
    dac_dunf = 1'b0; arm = 1'b1;
    step("unf_arm");
    arm = 1'b0;
    check("unf_cleared", 32'(unf_count), 32'd0);

    // Asynchronous reset mid-RUN.
    repeat (3) step("rst_run");
    @(posedge clk);
    model_update();
    #3 resetn = 1'b0;
    #1;
    check("rst_async_outputs", 32'(dut_vec()), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    repeat (5) begin
      step("rst_after");
      check("rst_no_valid", 32'(dac_valid), 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) ext_sync_mode = 1'($urandom_range(0, 1));
      arm        = ($urandom_range(0, 15) == 0);
      stop       = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) ext_sync_in = ~ext_sync_in;
      enable     = NC'($urandom);
      link_ready = ($urandom_range(0, 7) != 0);
      dac_dunf   = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
